// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax row pipeline (Q4.12 fixed point).
package softmax_pkg;

    localparam int DEFAULT_N         = 4;
    localparam int DEFAULT_BIT_WIDTH = 16;
    localparam int DEFAULT_ROW_LEN   = 32;
    localparam int Q_FRAC            = 12;

    typedef logic signed [DEFAULT_BIT_WIDTH-1:0] data_t;

    localparam data_t Q_MIN = data_t'(-(2 ** (DEFAULT_BIT_WIDTH - 1)));

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_e;

endpackage

// File: rtl/softmax_max_subtract_vec_max_tree.sv
// Combinational signed maximum across N lanes, reduced as a balanced binary tree.
module vec_max_tree #(
    parameter int N         = 4,
    parameter int BIT_WIDTH = 16
) (
    input  logic [N*BIT_WIDTH-1:0]       i_data,
    output logic signed [BIT_WIDTH-1:0]  o_max
);

    if ((N < 1) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("vec_max_tree: N must be a power of two");
    end

    // Heap layout: leaves at [N..2N-1], node i combines children 2i and 2i+1.
    logic signed [BIT_WIDTH-1:0] node [1:2*N-1];

    always_comb begin
        node = '{default: '0};
        for (int unsigned k = 0; k < N; k++) begin
            node[N + k] = i_data[k*BIT_WIDTH +: BIT_WIDTH];
        end
        for (int unsigned i = N - 1; i >= 1; i--) begin
            node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
        end
    end

    assign o_max = node[1];

endmodule

// File: rtl/softmax_max_subtract.sv
// Row max finder and (x - max) replay stage feeding the softmax exp unit.
// Optional SOFTMAX_FLUSH_EN forces differences below FLUSH_TH to the most negative code.
module softmax_max_subtract
    import softmax_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int ROW_LEN   = DEFAULT_ROW_LEN,
    parameter int FLUSH_TH  = -24576
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [N*BIT_WIDTH-1:0] i_data,
    output logic                   o_valid,
    output logic [N*BIT_WIDTH-1:0] o_data,
    output logic                   o_last,
    output logic [BIT_WIDTH-1:0]   o_max
);

    localparam int BEATS = ROW_LEN / N;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic signed [BIT_WIDTH-1:0] SAT_MIN   = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic signed [BIT_WIDTH:0]   SAT_MIN_W = {2'b11, {(BIT_WIDTH-1){1'b0}}};
    localparam logic signed [BIT_WIDTH:0]   FLUSH_W   = (BIT_WIDTH+1)'(FLUSH_TH);

    if ((ROW_LEN % N) != 0) begin : g_bad_row
        $error("softmax_max_subtract: ROW_LEN must be a multiple of N");
    end
    if ((FLUSH_TH > 0) || (FLUSH_TH < -(2 ** (BIT_WIDTH - 1)))) begin : g_bad_flush
        $error("softmax_max_subtract: FLUSH_TH outside the representable non-positive range");
    end

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]             rd_cnt_q, rd_cnt_d;
    logic signed [BIT_WIDTH-1:0]  max_q, max_d;
    logic [BIT_WIDTH-1:0]         o_max_q, o_max_d;
    logic [N*BIT_WIDTH-1:0]       buf_q [0:BEATS-1];
    logic [N*BIT_WIDTH-1:0]       buf_d [0:BEATS-1];
    logic                         o_valid_q, o_valid_d;
    logic                         o_last_q, o_last_d;
    logic [N*BIT_WIDTH-1:0]       o_data_q, o_data_d;

    logic signed [BIT_WIDTH-1:0]  lane_max;
    logic signed [BIT_WIDTH-1:0]  max_seed;
    logic signed [BIT_WIDTH-1:0]  new_max;
    logic signed [BIT_WIDTH-1:0]  elem;
    logic signed [BIT_WIDTH:0]    diff;
    logic signed [BIT_WIDTH-1:0]  lane_out;
    logic [N*BIT_WIDTH-1:0]       drain_data;

    vec_max_tree #(
        .N         (N),
        .BIT_WIDTH (BIT_WIDTH)
    ) u_max_tree (
        .i_data (i_data),
        .o_max  (lane_max)
    );

    assign max_seed = (beat_cnt_q == '0) ? SAT_MIN : max_q;
    assign new_max  = (lane_max > max_seed) ? lane_max : max_seed;

    // Subtraction is done one bit wider so the full [-(2^BW-1), 0] range is exact before clamping.
    always_comb begin
        elem       = '0;
        diff       = '0;
        lane_out   = '0;
        drain_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            elem = buf_q[rd_cnt_q][k*BIT_WIDTH +: BIT_WIDTH];
            diff = $signed({elem[BIT_WIDTH-1], elem}) - $signed({o_max_q[BIT_WIDTH-1], o_max_q});
            if (diff < SAT_MIN_W) begin
                lane_out = SAT_MIN;
            end else begin
                lane_out = diff[BIT_WIDTH-1:0];
            end
`ifdef SOFTMAX_FLUSH_EN
            if (diff < FLUSH_W) begin
                lane_out = SAT_MIN;
            end
`endif
            drain_data[k*BIT_WIDTH +: BIT_WIDTH] = lane_out;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        max_d      = max_q;
        o_max_d    = o_max_q;
        buf_d      = buf_q;
        o_valid_d  = 1'b0;
        o_last_d   = 1'b0;
        o_data_d   = o_data_q;
        case (state_q)
            COLLECT: begin
                if (i_valid) begin
                    buf_d[beat_cnt_q] = i_data;
                    max_d             = new_max;
                    beat_cnt_d        = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d  = DRAIN;
                        rd_cnt_d = '0;
                        o_max_d  = new_max;
                    end
                end
            end
            DRAIN: begin
                o_valid_d = 1'b1;
                o_data_d  = drain_data;
                rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_q == LAST_BEAT) begin
                    o_last_d   = 1'b1;
                    state_d    = COLLECT;
                    beat_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= COLLECT;
            beat_cnt_q <= '0;
            rd_cnt_q   <= '0;
            max_q      <= SAT_MIN;
            o_max_q    <= '0;
            for (int unsigned b = 0; b < BEATS; b++) begin
                buf_q[b] <= '0;
            end
            o_valid_q  <= 1'b0;
            o_last_q   <= 1'b0;
            o_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            max_q      <= max_d;
            o_max_q    <= o_max_d;
            buf_q      <= buf_d;
            o_valid_q  <= o_valid_d;
            o_last_q   <= o_last_d;
            o_data_q   <= o_data_d;
        end
    end

    assign i_ready = (state_q == COLLECT);
    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_data  = o_data_q;
    assign o_max   = o_max_q;

endmodule

// File: tb/tb_softmax_max_subtract.sv
// Scoreboard bench for softmax_max_subtract: rows modelled with plain integer arithmetic.
module tb_softmax_max_subtract;
    import softmax_pkg::*;

    localparam int N       = 4;
    localparam int BW      = 16;
    localparam int ROW_LEN = 32;
    localparam int BEATS   = ROW_LEN / N;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          i_ready;
    logic [N*BW-1:0] i_data;
    logic          o_valid;
    logic [N*BW-1:0] o_data;
    logic          o_last;
    logic [BW-1:0] o_max;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [N*BW-1:0] data;
        logic            last;
        logic [BW-1:0]   mx;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   row[ROW_LEN];
    int   saved_row[ROW_LEN];

    softmax_max_subtract #(
        .N         (N),
        .BIT_WIDTH (BW),
        .ROW_LEN   (ROW_LEN),
        .FLUSH_TH  (-24576)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_max   (o_max)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int ref_lane(int x, int mx);
        int d;
        d = x - mx;
        if (d < -32768) d = -32768;
`ifdef SOFTMAX_FLUSH_EN
        if (d < -24576) d = -32768;
`endif
        return d;
    endfunction

    function automatic logic [N*BW-1:0] beat_of(int b);
        logic [N*BW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*BW +: BW] = BW'(row[b*N + k]);
        return v;
    endfunction

    task automatic push_row(input int t_last);
        int   mx;
        exp_t e;
        mx = row[0];
        foreach (row[i]) if (row[i] > mx) mx = row[i];
        for (int b = 0; b < BEATS; b++) begin
            e.data = '0;
            for (int k = 0; k < N; k++) e.data[k*BW +: BW] = BW'(ref_lane(row[b*N + k], mx));
            e.last = (b == BEATS - 1);
            e.mx   = BW'(mx);
            e.cyc  = t_last + 1 + b;
            exp_q.push_back(e);
        end
    endtask

    // Leaves the beat on the bus; returns the edge number at which it will be accepted.
    task automatic send_beat(input int b, output int waited, output int t_acc);
        i_valid = 1'b1;
        i_data  = beat_of(b);
        waited  = 0;
        while (!i_ready && waited < 100) begin
            @(negedge i_clk);
            waited++;
        end
        if (!i_ready) begin
            $display("FAIL ready_timeout: i_ready stuck low for %0d cycles", waited);
            $fatal(1, "ready timeout");
        end
        t_acc = cyc + 1;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle after every beat, 2 random idle 0..3
    task automatic send_row(input int gap_mode, input bit hold_after, output int first_wait);
        int w, t, g;
        for (int b = 0; b < BEATS; b++) begin
            send_beat(b, w, t);
            if (b == 0) first_wait = w;
            if (b == BEATS - 1) push_row(t);
            @(negedge i_clk);
            if (!(b == BEATS - 1 && hold_after)) begin
                g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
                if (g > 0) begin
                    i_valid = 1'b0;
                    repeat (g) @(negedge i_clk);
                end
            end
        end
        if (!hold_after) i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk("drain_complete", 128'(exp_q.size()), 128'd0);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_o_valid"}, 128'(o_valid), 128'd0);
        chk({tag, "_o_last"},  128'(o_last),  128'd0);
        chk({tag, "_o_data"},  128'(o_data),  128'd0);
        chk({tag, "_o_max"},   128'(o_max),   128'd0);
        chk({tag, "_i_ready"}, 128'(i_ready), 128'd1);
    endtask

    task automatic fill_random(input bit narrow);
        logic [BW-1:0] r;
        for (int i = 0; i < ROW_LEN; i++) begin
            if (narrow) begin
                row[i] = int'($urandom_range(0, 4000)) - 2000;
            end else begin
                r      = BW'($urandom);
                row[i] = int'($signed(r));
            end
        end
    endtask

    // Monitor: every cycle o_valid must match the scoreboard's expectation of a beat.
    initial begin : monitor
        exp_t e;
        bit   exp_valid;
        forever begin
            @(negedge i_clk);
            if (i_rst !== 1'b0) continue;
            exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("o_valid", 128'(o_valid), 128'(exp_valid));
            if (exp_valid) begin
                e = exp_q.pop_front();
                chk("o_data", 128'(o_data), 128'(e.data));
                chk("o_last", 128'(o_last), 128'(e.last));
                chk("o_max",  128'(o_max),  128'(e.mx));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int w;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // Single positive peak among zeros
        foreach (row[i]) row[i] = 0;
        row[3*N + 2] = 1 << Q_FRAC;
        send_row(0, 1'b0, w);
        wait_idle();

        // One small negative among larger negatives
        foreach (row[i]) row[i] = -8000;
        row[$urandom_range(0, ROW_LEN - 1)] = -1000;
        saved_row = row;
        send_row(0, 1'b0, w);
        wait_idle();

        // Saturation extremes
        foreach (row[i]) row[i] = int'(Q_MIN);
        row[0] = 32767;
        row[2] = 4096;
        send_row(0, 1'b0, w);
        wait_idle();

        // Source keeps i_valid high across the drain
        fill_random(1'b0);
        send_row(0, 1'b1, w);
        fill_random(1'b1);
        send_row(0, 1'b0, w);
        chk("hold_ready_wait", 128'(w), 128'(BEATS));
        wait_idle();

        // Asynchronous reset after three accepted beats
        fill_random(1'b0);
        for (int b = 0; b < 3; b++) begin
            int tw, ta;
            send_beat(b, tw, ta);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_rst   = 1'b1;
        #1;
        check_reset_outputs("midrow_reset");
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        fill_random(1'b0);
        send_row(0, 1'b0, w);
        wait_idle();

        // Same data as the negative-row case, with i_valid toggling
        row = saved_row;
        send_row(1, 1'b0, w);
        wait_idle();

        // Randomized rows with random gaps, mixing full-range and narrow values
        for (int r = 0; r < 20; r++) begin
            fill_random(1'($urandom_range(0, 1)));
            send_row(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), w);
        end
        i_valid = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
